// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// Both rtl files import this package.
package mcycle_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] MCOP_NONE = 2'b00;
    localparam logic [1:0] MCOP_MUL  = 2'b01;
    localparam logic [1:0] MCOP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPUTE  = 2'd1,
        ST_SIGN_FIX = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/mcycle_iter_step.sv
// One iteration of the engine: shift-add for multiply, restoring trial
// subtract for divide. Purely combinational.
module mcycle_iter_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        // When the subtract succeeds the true difference is below opnd, so
        // the low WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            hi_nxt = fits ? diff : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], fits};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mcycle_sequencer.sv
// Iterative multiply/divide engine with stall (Busy) and completion (Done).
// Optional build macro MCYCLE_SIGNED_EN selects two's-complement operands.
//
// state     | meaning
// IDLE      | waiting for Start with a valid MCOp
// COMPUTE   | one iteration per cycle, WIDTH cycles
// SIGN_FIX  | apply result signs (MCYCLE_SIGNED_EN only)
// DONE      | results valid, Done pulse, Start ignored
module mcycle_sequencer
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    state_e           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd_b;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             op_div;
    logic             start_ok;
    logic             last;
`ifdef MCYCLE_SIGNED_EN
    logic             neg_q, neg_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
`endif

    assign start_ok = Start && (MCOp == MCOP_MUL || MCOp == MCOP_DIV);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign Done     = (state == ST_DONE);

    mcycle_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_div),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd_b),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    Busy      = 1'b1;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                Busy = 1'b1;
                if (last) begin
`ifdef MCYCLE_SIGNED_EN
                    state_nxt = ST_SIGN_FIX;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef MCYCLE_SIGNED_EN
            ST_SIGN_FIX: begin
                Busy      = 1'b1;
                state_nxt = ST_DONE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opnd_b  <= '0;
            op_div  <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
`ifdef MCYCLE_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cnt    <= '0;
                        hi     <= '0;
                        op_div <= (MCOp == MCOP_DIV);
`ifdef MCYCLE_SIGNED_EN
                        lo     <= (MCOp == MCOP_DIV) ? mag(Operand1) : mag(Operand2);
                        opnd_b <= (MCOp == MCOP_DIV) ? mag(Operand2) : mag(Operand1);
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_q  <= (Operand1[WIDTH-1] ^ Operand2[WIDTH-1])
                                  && (MCOp == MCOP_MUL || Operand2 != '0);
                        neg_r  <= Operand1[WIDTH-1];
`else
                        lo     <= (MCOp == MCOP_DIV) ? Operand1 : Operand2;
                        opnd_b <= (MCOp == MCOP_DIV) ? Operand2 : Operand1;
`endif
                    end
                end
                ST_COMPUTE: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
`ifndef MCYCLE_SIGNED_EN
                    if (last) begin
                        Result1 <= lo_nxt;
                        Result2 <= hi_nxt;
                    end
`endif
                end
`ifdef MCYCLE_SIGNED_EN
                ST_SIGN_FIX: begin
                    if (!op_div) begin
                        {Result2, Result1} <= neg_q ? -{hi, lo} : {hi, lo};
                    end else begin
                        Result1 <= neg_q ? -lo : lo;
                        Result2 <= neg_r ? -hi : hi;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: directed cases plus random
// operations against an arithmetic reference model.
module tb_mcycle_sequencer;

    localparam int W = 32;
`ifdef MCYCLE_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_r1 = '0;
    logic [W-1:0] last_r2 = '0;

    always #5 CLK = ~CLK;

    mcycle_sequencer #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCOp     (MCOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {Result2, Result1} computed with plain arithmetic.
    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] q, r;
`ifdef MCYCLE_SIGNED_EN
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b01) begin
            p = sa * sb;
            return p[2*W-1:0];
        end
        if (b == '0) return {a, {W{1'b1}}};
        q = W'(sa / sb);
        r = W'(sa % sb);
`else
        longint unsigned ua, ub, p;
        ua = longint'(a);
        ub = longint'(b);
        if (op == 2'b01) begin
            p = ua * ub;
            return p[2*W-1:0];
        end
        if (b == '0) return {a, {W{1'b1}}};
        q = a / b;
        r = a % b;
`endif
        return {r, q};
    endfunction

    // Called in an IDLE cycle just after a rising edge; returns in the IDLE
    // cycle following DONE with Start low.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input string name);
        logic [2*W-1:0] exp;
        exp      = model(op, a, b);
        Start    = 1'b1;
        MCOp     = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        chk({name, " busy_c0"}, Busy, 1);
        chk({name, " done_c0"}, Done, 0);
        for (int c = 1; c <= LAT; c++) begin
            @(posedge CLK);
            #1;
            if (c == 1) begin
                if (!hold) Start = 1'b0;
                Operand1 = $urandom;
                Operand2 = $urandom;
            end
            chk($sformatf("%s busy_c%0d", name, c), Busy, (c < LAT));
            chk($sformatf("%s done_c%0d", name, c), Done, (c == LAT));
            if (c < LAT) begin
                chk($sformatf("%s r1_hold_c%0d", name, c), Result1, last_r1);
                chk($sformatf("%s r2_hold_c%0d", name, c), Result2, last_r2);
            end
        end
        chk({name, " result1"}, Result1, exp[W-1:0]);
        chk({name, " result2"}, Result2, exp[2*W-1:W]);
        last_r1 = exp[W-1:0];
        last_r2 = exp[2*W-1:W];
        @(posedge CLK);
        #1;
        Start = 1'b0;
        #1;
        chk({name, " busy_after"}, Busy, 0);
        chk({name, " done_after"}, Done, 0);
        chk({name, " r1_stable"}, Result1, last_r1);
        chk({name, " r2_stable"}, Result2, last_r2);
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        RESET    = 1'b1;
        Start    = 1'b0;
        MCOp     = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("reset busy", Busy, 0);
        chk("reset done", Done, 0);
        chk("reset r1", Result1, 0);
        chk("reset r2", Result2, 0);

        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_2p32");
        chk("mul_2p32 hi", Result2, 32'h0000_0001);
        chk("mul_2p32 lo", Result1, 32'h0000_0000);

        // Start held through DONE must not launch a second operation.
        run_op(2'b10, 32'd100, 32'd7, 1'b1, "div_100_7");
        chk("div_100_7 q", Result1, 32'd14);
        chk("div_100_7 r", Result2, 32'd2);
        repeat (3) begin
            @(posedge CLK);
            #1;
            chk("hold no_restart busy", Busy, 0);
            chk("hold no_restart done", Done, 0);
        end

        run_op(2'b10, 32'h0000_1234, 32'h0, 1'b0, "div_by_zero");
        chk("div_by_zero q", Result1, 32'hFFFF_FFFF);
        chk("div_by_zero r", Result2, 32'h0000_1234);

        for (int k = 0; k < 2; k++) begin
            Start    = 1'b1;
            MCOp     = (k == 0) ? 2'b00 : 2'b11;
            Operand1 = $urandom;
            Operand2 = $urandom;
            #1;
            chk($sformatf("nop%0d busy_c0", k), Busy, 0);
            repeat (3) begin
                @(posedge CLK);
                #1;
                chk($sformatf("nop%0d busy", k), Busy, 0);
                chk($sformatf("nop%0d done", k), Done, 0);
                chk($sformatf("nop%0d r1", k), Result1, last_r1);
                chk($sformatf("nop%0d r2", k), Result2, last_r2);
            end
            Start = 1'b0;
            #1;
        end

        Start    = 1'b1;
        MCOp     = 2'b01;
        Operand1 = 32'hFFFF_FFFF;
        Operand2 = 32'd2;
        #1;
        chk("rst_mid busy_c0", Busy, 1);
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK);
            #1;
            if (c == 1) Start = 1'b0;
            if (c == 10) RESET = 1'b1;
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_mid busy_c11", Busy, 0);
        chk("rst_mid done_c11", Done, 0);
        chk("rst_mid r1_c11", Result1, 0);
        chk("rst_mid r2_c11", Result2, 0);
        last_r1 = '0;
        last_r2 = '0;
        repeat (LAT) begin
            @(posedge CLK);
            #1;
            chk("rst_mid no_done", Done, 0);
        end
        #1;
        run_op(2'b01, 32'd3, 32'd5, 1'b0, "mul_3_5");
        chk("mul_3_5 lo", Result1, 32'd15);
        chk("mul_3_5 hi", Result2, 32'd0);

`ifdef MCYCLE_SIGNED_EN
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "sdiv_m7_2");
        chk("sdiv_m7_2 q", Result1, 32'hFFFF_FFFD);
        chk("sdiv_m7_2 r", Result2, 32'hFFFF_FFFF);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd4, 1'b0, "smul_m3_4");
        chk("smul_m3_4 lo", Result1, 32'hFFFF_FFF4);
        chk("smul_m3_4 hi", Result2, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
# mcycle_sequencer

Iterative multi-cycle multiply/divide engine with its sequencing FSM, placed beside the ALU in the single-cycle ARM datapath. Accepts the decoder's start pulse and operation code (MCOp: 01 multiply, 10 divide), runs a shift-add multiply or restoring divide over WIDTH iterations, and holds Busy so the processor stalls the PC and register write-back until results are ready.

## Interface
- WIDTH, 32: operand and result width; also the iteration count.
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  request from decoder; sampled only in IDLE.
- MCOp  in  2  operation: 01 MUL, 10 DIV; 00/11 = no operation.
- Operand1  in  WIDTH  multiplicand / dividend; sampled with Start.
- Operand2  in  WIDTH  multiplier / divisor; sampled with Start.
- Result1  out  WIDTH  product low word / quotient.
- Result2  out  WIDTH  product high word / remainder.
- Busy  out  1  stall request to PC and register file.
- Done  out  1  one-cycle pulse; results valid and stable.

## Operation
- States: IDLE, COMPUTE, (SIGN_FIX with macro), DONE.
- IDLE: Start=1 and MCOp ∈ {01,10} → latch operands and op, clear iteration counter, go COMPUTE. Other MCOp values ignored.
- COMPUTE: one iteration per cycle; counter runs 0..WIDTH-1; at WIDTH-1 go DONE (or SIGN_FIX).
- MUL: 2·WIDTH-bit shift-add accumulator; full unsigned product; Result2:Result1 = product.
- DIV: restoring; partial remainder shifts in one dividend bit per cycle, subtract divisor when non-negative, quotient bit = 1 on success.
- Divide by zero: no special path; algorithm yields Result1 = all ones, Result2 = Operand1, normal latency.
- DONE: Done=1, Busy=0, results updated; Start ignored this cycle (the stalled instruction commits with Start still high); next state IDLE.
- Results hold last values until the next completion; never change mid-computation.
- Reset values: state IDLE, counter 0, Result1=0, Result2=0, Busy=0, Done=0.

## Timing
- Busy = (IDLE & Start & MCOp valid) | COMPUTE | SIGN_FIX; combinational, so the stall takes effect the same cycle Start is first asserted.
- Start in cycle 0 → Busy high cycles 0..WIDTH (unsigned), Done high in cycle WIDTH+1, Busy low that cycle.
- Back-to-back: new Start accepted earliest in the cycle after DONE.
- RESET mid-operation: IDLE next cycle, no Done pulse, results cleared; RESET wins over Start in the same cycle.
- Operand changes after cycle 0 have no effect.

## Configuration
- MCYCLE_SIGNED_EN defined: operands are two's complement. COMPUTE works on magnitudes; extra SIGN_FIX cycle negates results. Product sign = XOR of operand signs; quotient truncates toward zero; remainder takes dividend sign. Latency +1 cycle (Done in cycle WIDTH+2). Divide by zero: Result1 = all ones, Result2 = Operand1.
- Undefined: unsigned only; no SIGN_FIX state; latency as in Timing.

## Structure
- Package mcycle_pkg: MCOp encodings (MCOP_NONE 00, MCOP_MUL 01, MCOP_DIV 10), state encoding constants, default WIDTH.
- Sub-module mcycle_iter_step: combinational single iteration (add-or-pass for MUL, trial subtract for DIV), instantiated once; FSM, counter and registers stay in mcycle_sequencer.

## Test plan
- MUL 0x0001_0000 × 0x0001_0000 → Done in cycle 33, Result2=0x0000_0001, Result1=0x0000_0000, Busy high cycles 0..32.
- DIV 100 / 7 → Result1=14, Result2=2; Done exactly one cycle; Start held high through DONE produces no second operation.
- DIV 0x1234 / 0 → Result1=0xFFFF_FFFF, Result2=0x0000_1234, normal latency.
- Start with MCOp=00 and 11 → Busy stays 0, no Done, results unchanged.
- MUL 0xFFFF_FFFF × 2, RESET asserted in cycle 10 → cycle 11 Busy=0, Result1=Result2=0, no Done; a fresh MUL 3 × 5 afterwards gives Result1=15, Result2=0.
- With MCYCLE_SIGNED_EN: DIV -7 / 2 → Result1=0xFFFF_FFFD, Result2=0xFFFF_FFFF; MUL -3 × 4 → Result1=0xFFFF_FFF4, Result2=0xFFFF_FFFF; Done in cycle 34.
